dsp_mac_pipe: RTL
=================

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- A_W, 8, multiplicand width.
- B_W, 8, multiplier width.
- ACC_W, 20, accumulator and cascade width; must satisfy ACC_W >= A_W+B_W.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- UserCLK, in, 1, sole clock.
- RESETn, in, 1, asynchronous active-low reset.
- ConfigBits, in, 4, static mode: [0] SIGNED, [1] ACC_EN, [2] IN_REG, [3] ADD_SRC.
- CE, in, 1, clock enable for all stages.
- CLR, in, 1, synchronous accumulator clear.
- IN_VALID, in, 1, A and B are valid.
- A, in, A_W, multiplicand.
- B, in, B_W, multiplier.
- C, in, ACC_W, external addend.
- CASC_IN, in, ACC_W, cascade addend from the tile above.
- Q, out, ACC_W, accumulator value.
- CASC_OUT, out, ACC_W, equals Q, routed to the tile below.
- OUT_VALID, out, 1, Q updated by a valid operation this cycle.
- OVF, out, 1, sticky overflow flag.
REQ-003 The clock SHALL be single (UserCLK); reset SHALL be asynchronous, active-low (RESETn).

Function
REQ-004 Pipeline: S0 optional input register, S1 product register, S2 accumulator register; a valid flag travels alongside each stage.
REQ-005 IN_REG=1: IN_VALID at edge t SHALL give OUT_VALID at edge t+3. IN_REG=0: S0 is bypassed and latency SHALL be 2.
REQ-006 SIGNED=1: A, B and the addend SHALL be two's complement, with the product sign-extended to ACC_W. SIGNED=0: all are unsigned and zero-extended.
REQ-007 The addend SHALL be C when ADD_SRC=0 and CASC_IN when ADD_SRC=1.
REQ-008 On a valid S2 update: ACC_EN=1 gives acc <= acc + product; ACC_EN=0 gives acc <= addend + product.
REQ-009 CE=0 SHALL freeze every data and valid register, and OUT_VALID SHALL be 0 that cycle.
REQ-010 CLR alone SHALL set acc to 0 and SHALL clear OVF.
REQ-011 CLR together with a valid S2 update SHALL treat the feedback term as 0 (acc <= product, or addend+product when ACC_EN=0) and SHALL clear OVF.
REQ-012 A bubble (valid flag 0) at S2 SHALL hold acc.
REQ-013 Overflow SHALL be detected on the ACC_W-bit sum: signed overflow on sign mismatch, unsigned overflow on carry-out. OVF SHALL set and hold until CLR or reset.
REQ-014 Changing ConfigBits mid-stream is unsupported; results are undefined until a new CLR.

Reset
REQ-015 RESETn low SHALL asynchronously set all pipeline registers, valid flags, Q, CASC_OUT, OUT_VALID and OVF to 0.
REQ-016 Release SHALL be synchronised to UserCLK by the integrating tile. In-flight operations are discarded on reset.

Configuration
REQ-017 Saturation SHALL be controlled by macro DSP_MAC_SAT_EN.
- Defined: on overflow, acc clamps to the max or min representable ACC_W value per signedness, and OVF sets.
- Undefined: acc wraps modulo 2^ACC_W and OVF still sets.

Structure
REQ-018 Package dsp_mac_pkg SHALL hold the ConfigBits index constants (CFG_SIGNED=0, CFG_ACC_EN=1, CFG_IN_REG=2, CFG_ADD_SRC=3), NCFG=4 and the default widths.
REQ-019 The add/overflow/saturate logic SHALL be one sub-module, dsp_mac_addsat, parametrised by ACC_W.

Verification
REQ-020 Unsigned MAC: Config=0b0110, A=3, B=4, then A=5, B=6, CE=1 -> OUT_VALID at t+3 with Q=12, then Q=42.
REQ-021 Signed load: Config=0b0001, A=-2 (0xFE), B=7, C=10 -> after 2 cycles Q=-4 (0xFFFFC), OVF=0.
REQ-022 Cascade: Config=0b1000, CASC_IN=100, A=2, B=3 -> Q=106 and CASC_OUT=106.
REQ-023 Overflow (ACC_W=20, unsigned, ACC_EN): acc=0xFFF00 plus A=255, B=255 -> wrap to 0x0FD01 with OVF=1, or 0xFFFFF with OVF=1 when DSP_MAC_SAT_EN is defined; CLR then gives Q=0 and OVF=0.
REQ-024 CE=0 for 2 cycles mid-stream -> outputs and valid flags hold; OUT_VALID resumes 2 cycles late with the correct sum.
REQ-025 RESETn asserted with a non-zero acc and in-flight data -> all outputs 0 immediately; no OUT_VALID follows reset release.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared constants and the ConfigBits view for the dsp_mac_pipe slice.
package dsp_mac_pkg;

  localparam int unsigned NCFG = 4;

  localparam int unsigned CFG_SIGNED  = 0;
  localparam int unsigned CFG_ACC_EN  = 1;
  localparam int unsigned CFG_IN_REG  = 2;
  localparam int unsigned CFG_ADD_SRC = 3;

  localparam int unsigned A_W_DEF   = 8;
  localparam int unsigned B_W_DEF   = 8;
  localparam int unsigned ACC_W_DEF = 20;

  // Field order mirrors ConfigBits[3:0] so a plain cast decodes it.
  typedef struct packed {
    logic add_src;
    logic in_reg;
    logic acc_en;
    logic is_signed;
  } cfg_t;

endpackage

// File: rtl/dsp_mac_addsat.sv
// ACC_W-bit adder with signed/unsigned overflow detection.
// With DSP_MAC_SAT_EN defined the sum clamps on overflow, otherwise it wraps.
module dsp_mac_addsat #(
  parameter int unsigned ACC_W = 20
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  input  logic             signed_i,
  output logic [ACC_W-1:0] sum_o_c,
  output logic             ovf_o_c
);

  localparam int unsigned MSB = ACC_W - 1;

  logic [ACC_W:0] raw;

  always_comb begin
    raw     = {1'b0, a_i} + {1'b0, b_i};
    ovf_o_c = 1'b0;
    sum_o_c = raw[ACC_W-1:0];
    if (signed_i) begin
      ovf_o_c = (a_i[MSB] == b_i[MSB]) && (raw[MSB] != a_i[MSB]);
    end else begin
      ovf_o_c = raw[ACC_W];
    end
`ifdef DSP_MAC_SAT_EN
    // Signed overflow only happens with equal operand signs, so a_i's sign picks the rail.
    if (ovf_o_c) begin
      if (!signed_i) begin
        sum_o_c = '1;
      end else if (a_i[MSB]) begin
        sum_o_c = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum_o_c = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
`endif
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined multiply-accumulate tile: optional input reg, product reg, accumulator.
// Optional saturation on accumulator overflow via macro DSP_MAC_SAT_EN.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned B_W   = B_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              UserCLK,
  input  logic              RESETn,
  input  logic [NCFG-1:0]   ConfigBits,
  input  logic              CE,
  input  logic              CLR,
  input  logic              IN_VALID,
  input  logic [A_W-1:0]    A,
  input  logic [B_W-1:0]    B,
  input  logic [ACC_W-1:0]  C,
  input  logic [ACC_W-1:0]  CASC_IN,
  output logic [ACC_W-1:0]  Q,
  output logic [ACC_W-1:0]  CASC_OUT,
  output logic              OUT_VALID,
  output logic              OVF
);

  localparam int unsigned PW = A_W + B_W + 2;

  cfg_t cfg;
  assign cfg = cfg_t'(ConfigBits);

  logic [A_W-1:0]          a0_q;
  logic [B_W-1:0]          b0_q;
  logic                    v0_q;
  logic [A_W-1:0]          a_s1;
  logic [B_W-1:0]          b_s1;
  logic                    v_s1;
  logic signed [A_W:0]     a_ext;
  logic signed [B_W:0]     b_ext;
  logic signed [PW-1:0]    prod_full;
  logic [ACC_W-1:0]        prod_d;
  logic [ACC_W-1:0]        prod_q;
  logic                    v1_q;
  logic [ACC_W-1:0]        addend;
  logic [ACC_W-1:0]        fb;
  logic [ACC_W-1:0]        sum;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        acc_d;
  logic [ACC_W-1:0]        acc_q;
  logic                    ovf_d;
  logic                    ovf_q;
  logic                    oval_d;
  logic                    oval_q;

  // S0: optional input register.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      a0_q <= '0;
      b0_q <= '0;
      v0_q <= 1'b0;
    end else if (CE) begin
      a0_q <= A;
      b0_q <= B;
      v0_q <= IN_VALID;
    end
  end

  assign a_s1 = cfg.in_reg ? a0_q : A;
  assign b_s1 = cfg.in_reg ? b0_q : B;
  assign v_s1 = cfg.in_reg ? v0_q : IN_VALID;

  // One extra bit per operand makes a single signed multiply cover both modes.
  always_comb begin
    a_ext     = cfg.is_signed ? {a_s1[A_W-1], a_s1} : {1'b0, a_s1};
    b_ext     = cfg.is_signed ? {b_s1[B_W-1], b_s1} : {1'b0, b_s1};
    prod_full = PW'(a_ext) * PW'(b_ext);
    prod_d    = ACC_W'({{ACC_W{prod_full[PW-1]}}, prod_full});
  end

  // S1: product register.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
    end else if (CE) begin
      prod_q <= prod_d;
      v1_q   <= v_s1;
    end
  end

  always_comb begin
    addend = cfg.add_src ? CASC_IN : C;
    fb     = cfg.acc_en ? acc_q : addend;
    if (CLR && cfg.acc_en) begin
      fb = '0;
    end
  end

  dsp_mac_addsat #(
    .ACC_W (ACC_W)
  ) u_addsat (
    .a_i      (fb),
    .b_i      (prod_q),
    .signed_i (cfg.is_signed),
    .sum_o_c  (sum),
    .ovf_o_c  (sum_ovf)
  );

  // S2 next state: valid update, standalone clear, or hold.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    oval_d = 1'b0;
    if (CE) begin
      if (v1_q) begin
        acc_d  = sum;
        ovf_d  = (ovf_q & ~CLR) | sum_ovf;
        oval_d = 1'b1;
      end else if (CLR) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      oval_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      oval_q <= oval_d;
    end
  end

  assign Q         = acc_q;
  assign CASC_OUT  = acc_q;
  assign OUT_VALID = oval_q;
  assign OVF       = ovf_q;

endmodule
